// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM for the RV32I datapath (R-type, ADDI, LW, SW, BEQ).
// Sequences fetch/decode/execute/memory/writeback, drives datapath selects and strobes,
// and aborts memory waits that exceed TIMEOUT cycles.
module multicycle_main_control #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction_i,
   input  logic        mem_ready_i,
   output logic [1:0]  alu_op_o,
   output logic [1:0]  alu_src_a_o,
   output logic [1:0]  alu_src_b_o,
   output logic [1:0]  result_src_o,
   output logic        addr_src_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic        ir_write_o,
   output logic        pc_write_o,
   output logic        branch_o,
   output logic        reg_write_o,
   output logic        illegal_o,
   output logic        mem_timeout_o,
   output logic [3:0]  state_o
);

   localparam logic [3:0] StFetch   = 4'd0;
   localparam logic [3:0] StDecode  = 4'd1;
   localparam logic [3:0] StMemAddr = 4'd2;
   localparam logic [3:0] StMemRd   = 4'd3;
   localparam logic [3:0] StMemWb   = 4'd4;
   localparam logic [3:0] StMemWr   = 4'd5;
   localparam logic [3:0] StExecR   = 4'd6;
   localparam logic [3:0] StExecI   = 4'd7;
   localparam logic [3:0] StAluWb   = 4'd8;
   localparam logic [3:0] StBranch  = 4'd9;

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;

   // Counter only needs to reach TIMEOUT-1.
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   logic [3:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [6:0]      opcode;
   logic            waiting;
   logic            expire;
   logic            unused_instr;

   assign opcode       = instruction_i[6:0];
   assign unused_instr = ^instruction_i[31:7];

   // Watchdog: only states issuing a memory request wait on mem_ready; ready wins over expiry.
   always_comb begin
      waiting = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
      expire  = (TIMEOUT != 0) && waiting && !mem_ready_i && (cnt_q == CntLast);
      cnt_d   = '0;
      if ((TIMEOUT != 0) && waiting && !mem_ready_i && !expire) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Next-state logic; a timed-out wait always falls back to FETCH.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch: begin
            if (mem_ready_i) begin
               state_d = StDecode;
            end else if (expire) begin
               state_d = StFetch;
            end
         end
         StDecode: begin
            case (opcode)
               OpR:              state_d = StExecR;
               OpImm:            state_d = StExecI;
               OpLoad, OpStore:  state_d = StMemAddr;
               OpBranch:         state_d = StBranch;
               default:          state_d = StFetch;
            endcase
         end
         StMemAddr: begin
            if (opcode == OpLoad) begin
               state_d = StMemRd;
            end else if (opcode == OpStore) begin
               state_d = StMemWr;
            end else begin
               state_d = StFetch;
            end
         end
         StMemRd: begin
            if (mem_ready_i) begin
               state_d = StMemWb;
            end else if (expire) begin
               state_d = StFetch;
            end
         end
         StMemWr: begin
            if (mem_ready_i || expire) begin
               state_d = StFetch;
            end
         end
         StExecR, StExecI:        state_d = StAluWb;
         StMemWb, StAluWb, StBranch: state_d = StFetch;
         default:                 state_d = StFetch;
      endcase
   end

   // Output decode from the current state; unlisted outputs stay 0.
   always_comb begin
      alu_op_o      = 2'b00;
      alu_src_a_o   = 2'b00;
      alu_src_b_o   = 2'b00;
      result_src_o  = 2'b00;
      addr_src_o    = 1'b0;
      mem_read_o    = 1'b0;
      mem_write_o   = 1'b0;
      ir_write_o    = 1'b0;
      pc_write_o    = 1'b0;
      branch_o      = 1'b0;
      reg_write_o   = 1'b0;
      illegal_o     = 1'b0;
      mem_timeout_o = expire;
      case (state_q)
         StFetch: begin
            mem_read_o   = 1'b1;
            alu_src_b_o  = 2'b10;
            result_src_o = 2'b10;
            ir_write_o   = mem_ready_i;
            pc_write_o   = mem_ready_i;
         end
         StDecode: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b01;
            illegal_o   = !(opcode inside {OpR, OpImm, OpLoad, OpStore, OpBranch});
         end
         StMemAddr: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
         end
         StMemRd: begin
            mem_read_o = 1'b1;
            addr_src_o = 1'b1;
         end
         StMemWb: begin
            result_src_o = 2'b01;
            reg_write_o  = 1'b1;
         end
         StMemWr: begin
            // An aborted write must not be committed by memory.
            mem_write_o = !expire;
            addr_src_o  = 1'b1;
         end
         StExecR: begin
            alu_src_a_o = 2'b10;
            alu_op_o    = 2'b10;
         end
         StExecI: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
         end
         StAluWb: begin
            reg_write_o = 1'b1;
         end
         StBranch: begin
            alu_src_a_o = 2'b10;
            alu_op_o    = 2'b01;
            branch_o    = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign state_o = state_q;

   // State and watchdog registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: a default instance and a TIMEOUT=4 instance share inputs.
// Directed vector table, hand-written corner sequences, then random stimulus against a
// sequence-level reference model.
module tb_multicycle_main_control;

   localparam int unsigned To0 = 16;
   localparam int unsigned To1 = 4;

   localparam logic [31:0] InstAdd  = 32'h002081B3;
   localparam logic [31:0] InstAddi = 32'h00108093;
   localparam logic [31:0] InstBeq  = 32'h00208463;
   localparam logic [31:0] InstIll  = 32'h0000007F;
   localparam logic [31:0] InstLw   = 32'h0000A083;
   localparam logic [31:0] InstSw   = 32'h0020A023;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        mr;

   logic [1:0] alu_op [2];
   logic [1:0] alu_src_a [2];
   logic [1:0] alu_src_b [2];
   logic [1:0] result_src [2];
   logic       addr_src [2];
   logic       mem_read [2];
   logic       mem_write [2];
   logic       ir_write [2];
   logic       pc_write [2];
   logic       branch [2];
   logic       reg_write [2];
   logic       illegal [2];
   logic       mem_timeout [2];
   logic [3:0] state [2];

   int chk = 0;
   int err = 0;

   multicycle_main_control #(.TIMEOUT(To0)) u_dut (
      .clk(clk), .rst_n(rst_n), .instruction_i(instr), .mem_ready_i(mr),
      .alu_op_o(alu_op[0]), .alu_src_a_o(alu_src_a[0]), .alu_src_b_o(alu_src_b[0]),
      .result_src_o(result_src[0]), .addr_src_o(addr_src[0]), .mem_read_o(mem_read[0]),
      .mem_write_o(mem_write[0]), .ir_write_o(ir_write[0]), .pc_write_o(pc_write[0]),
      .branch_o(branch[0]), .reg_write_o(reg_write[0]), .illegal_o(illegal[0]),
      .mem_timeout_o(mem_timeout[0]), .state_o(state[0])
   );

   multicycle_main_control #(.TIMEOUT(To1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .instruction_i(instr), .mem_ready_i(mr),
      .alu_op_o(alu_op[1]), .alu_src_a_o(alu_src_a[1]), .alu_src_b_o(alu_src_b[1]),
      .result_src_o(result_src[1]), .addr_src_o(addr_src[1]), .mem_read_o(mem_read[1]),
      .mem_write_o(mem_write[1]), .ir_write_o(ir_write[1]), .pc_write_o(pc_write[1]),
      .branch_o(branch[1]), .reg_write_o(reg_write[1]), .illegal_o(illegal[1]),
      .mem_timeout_o(mem_timeout[1]), .state_o(state[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed outputs: {alu_op, src_a, src_b, result_src, addr_src, mem_read, mem_write,
   //                  ir_write, pc_write, branch, reg_write, illegal, mem_timeout, state}
   function automatic logic [20:0] outs(input int k);
      return {alu_op[k], alu_src_a[k], alu_src_b[k], result_src[k], addr_src[k], mem_read[k],
              mem_write[k], ir_write[k], pc_write[k], branch[k], reg_write[k], illegal[k],
              mem_timeout[k], state[k]};
   endfunction

   // Per-state output table from the control description.
   function automatic logic [20:0] spec_out(input int st, input logic r, input logic ex,
                                            input logic ill);
      logic [1:0] op = 2'b00, a = 2'b00, b = 2'b00, rs = 2'b00;
      logic ad = 1'b0, rd = 1'b0, wr = 1'b0, ir = 1'b0, pc = 1'b0, br = 1'b0, rw = 1'b0;
      case (st)
         0: begin rd = 1'b1; b = 2'b10; rs = 2'b10; ir = r; pc = r; end
         1: begin a = 2'b01; b = 2'b01; end
         2: begin a = 2'b10; b = 2'b01; end
         3: begin rd = 1'b1; ad = 1'b1; end
         4: begin rs = 2'b01; rw = 1'b1; end
         5: begin wr = 1'b1; ad = 1'b1; end
         6: begin a = 2'b10; op = 2'b10; end
         7: begin a = 2'b10; b = 2'b01; end
         8: begin rw = 1'b1; end
         9: begin a = 2'b10; op = 2'b01; br = 1'b1; end
         default: begin end
      endcase
      return {op, a, b, rs, ad, rd, wr, ir, pc, br, rw, ill, ex, 4'(st)};
   endfunction

   // Instruction class: 0 R, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 unsupported.
   function automatic int classify(input logic [6:0] op);
      case (op)
         7'b0110011: return 0;
         7'b0010011: return 1;
         7'b0000011: return 2;
         7'b0100011: return 3;
         7'b1100011: return 4;
         default:    return 5;
      endcase
   endfunction

   // Reference model: each instruction class walks a fixed state sequence.
   int seq [6][5];
   int slen [6];
   int cls [2];
   int idx [2];
   int w [2];
   int tmo [2];

   function automatic int mstate(input int k);
      return seq[cls[k]][idx[k]];
   endfunction

   task automatic mdl(input int k, input logic r, input logic [6:0] op,
                      output logic [20:0] e, output logic [20:0] m);
      int st;
      logic wt, ex, ill;
      st  = mstate(k);
      wt  = (st == 0) || (st == 3) || (st == 5);
      ex  = (tmo[k] != 0) && wt && !r && (w[k] == tmo[k] - 1);
      ill = (st == 1) && (classify(op) == 5);
      e   = spec_out(st, r, ex, ill);
      m   = '0;
      // Write strobe during an aborted write is not compared.
      if (ex && st == 5) m[10] = 1'b1;
      if (wt && !r) begin
         if (ex) begin
            idx[k] = 0;
            w[k]   = 0;
         end else begin
            w[k]++;
         end
      end else begin
         w[k] = 0;
         if (st == 1) cls[k] = classify(op);
         idx[k]++;
         if (idx[k] >= slen[cls[k]]) idx[k] = 0;
      end
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mr    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic        mr;
      logic [3:0]  st;
      logic [1:0]  op;
      logic        rw;
      logic        br;
      logic        il;
      logic [1:0]  rs;
   } vec_t;

   vec_t vt [$];

   task automatic addv(input logic [31:0] i, input logic r, input logic [3:0] s,
                       input logic [1:0] o, input logic rw, input logic br, input logic il,
                       input logic [1:0] rs);
      vt.push_back('{instr: i, mr: r, st: s, op: o, rw: rw, br: br, il: il, rs: rs});
   endtask

   initial begin
      logic [20:0] e, m;
      logic [6:0]  ops [8];

      seq[0] = '{0, 1, 6, 8, 0}; slen[0] = 4;
      seq[1] = '{0, 1, 7, 8, 0}; slen[1] = 4;
      seq[2] = '{0, 1, 2, 3, 4}; slen[2] = 5;
      seq[3] = '{0, 1, 2, 5, 0}; slen[3] = 4;
      seq[4] = '{0, 1, 9, 0, 0}; slen[4] = 3;
      seq[5] = '{0, 1, 0, 0, 0}; slen[5] = 2;
      tmo[0] = To0;
      tmo[1] = To1;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1111111, 7'b0000000, 7'b0110111};

      // add: 0,1,6,8; mem_ready=0 in DECODE must be ignored
      addv(InstAdd, 1, 0, 2'b00, 0, 0, 0, 2'b10);
      addv(InstAdd, 0, 1, 2'b00, 0, 0, 0, 2'b00);
      addv(InstAdd, 1, 6, 2'b10, 0, 0, 0, 2'b00);
      addv(InstAdd, 0, 8, 2'b00, 1, 0, 0, 2'b00);
      // addi: 0,1,7,8
      addv(InstAddi, 1, 0, 2'b00, 0, 0, 0, 2'b10);
      addv(InstAddi, 1, 1, 2'b00, 0, 0, 0, 2'b00);
      addv(InstAddi, 1, 7, 2'b00, 0, 0, 0, 2'b00);
      addv(InstAddi, 1, 8, 2'b00, 1, 0, 0, 2'b00);
      // beq: 0,1,9
      addv(InstBeq, 1, 0, 2'b00, 0, 0, 0, 2'b10);
      addv(InstBeq, 1, 1, 2'b00, 0, 0, 0, 2'b00);
      addv(InstBeq, 0, 9, 2'b01, 0, 1, 0, 2'b00);
      // unsupported opcode: illegal pulse in DECODE, back to FETCH
      addv(InstIll, 1, 0, 2'b00, 0, 0, 0, 2'b10);
      addv(InstIll, 1, 1, 2'b00, 0, 0, 1, 2'b00);
      // lw with three stall cycles in MEM_RD (ready arrives as TIMEOUT=4 would expire)
      addv(InstLw, 1, 0, 2'b00, 0, 0, 0, 2'b10);
      addv(InstLw, 1, 1, 2'b00, 0, 0, 0, 2'b00);
      addv(InstLw, 1, 2, 2'b00, 0, 0, 0, 2'b00);
      addv(InstLw, 0, 3, 2'b00, 0, 0, 0, 2'b00);
      addv(InstLw, 0, 3, 2'b00, 0, 0, 0, 2'b00);
      addv(InstLw, 0, 3, 2'b00, 0, 0, 0, 2'b00);
      addv(InstLw, 1, 3, 2'b00, 0, 0, 0, 2'b00);
      addv(InstLw, 1, 4, 2'b00, 1, 0, 0, 2'b01);
      // sw with a one-cycle fetch stall
      addv(InstSw, 0, 0, 2'b00, 0, 0, 0, 2'b10);
      addv(InstSw, 1, 0, 2'b00, 0, 0, 0, 2'b10);
      addv(InstSw, 1, 1, 2'b00, 0, 0, 0, 2'b00);
      addv(InstSw, 1, 2, 2'b00, 0, 0, 0, 2'b00);
      addv(InstSw, 1, 5, 2'b00, 0, 0, 0, 2'b00);
      addv(InstAdd, 0, 0, 2'b00, 0, 0, 0, 2'b10);

      // Asynchronous reset assertion with no clock edge
      instr = InstAdd;
      mr    = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("reset_outputs dut%0d", k), 32'(outs(k)),
               32'(spec_out(0, 1'b0, 1'b0, 1'b0)));
      end
      do_reset();

      for (int i = 0; i < vt.size(); i++) begin
         instr = vt[i].instr;
         mr    = vt[i].mr;
         #1;
         check($sformatf("vec%0d", i),
               32'({state[0], alu_op[0], reg_write[0], branch[0], illegal[0], result_src[0]}),
               32'({vt[i].st, vt[i].op, vt[i].rw, vt[i].br, vt[i].il, vt[i].rs}));
         check($sformatf("vec%0d_t4_state", i), 32'(state[1]), 32'(vt[i].st));
         @(negedge clk);
      end

      // Reset between edges while waiting in MEM_RD
      do_reset();
      for (int j = 0; j < 3; j++) begin
         instr = InstLw;
         mr    = 1'b1;
         @(negedge clk);
      end
      mr = 1'b0;
      #1;
      check("memrd_reached", 32'(state[0]), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_state", 32'(state[0]), 32'd0);
      check("async_rst_strobes", 32'({mem_read[0], mem_write[0], reg_write[0]}), 32'b100);
      do_reset();

      // Watchdog expiry in MEM_WR on the TIMEOUT=4 instance only
      for (int j = 0; j < 3; j++) begin
         instr = InstSw;
         mr    = 1'b1;
         @(negedge clk);
      end
      for (int j = 0; j < 4; j++) begin
         mr = 1'b0;
         #1;
         check($sformatf("wr_wait%0d_state", j), 32'({state[0], state[1]}), 32'h55);
         check($sformatf("wr_wait%0d_tmo4", j), 32'(mem_timeout[1]), (j == 3) ? 32'd1 : 32'd0);
         check($sformatf("wr_wait%0d_tmo16", j), 32'(mem_timeout[0]), 32'd0);
         @(negedge clk);
      end
      #1;
      check("after_timeout_states", 32'({state[0], state[1]}), 32'h50);
      do_reset();

      // Random stimulus against the reference model
      for (int k = 0; k < 2; k++) begin
         cls[k] = 5;
         idx[k] = 0;
         w[k]   = 0;
      end
      for (int c = 0; c < 4000; c++) begin
         // Opcode only changes while both models sit in FETCH
         if (mstate(0) == 0 && mstate(1) == 0) begin
            instr      = $urandom();
            instr[6:0] = ops[$urandom_range(0, 7)];
         end
         if (c < 2000) mr = 1'($urandom_range(0, 1));
         else          mr = ($urandom_range(0, 6) == 0);
         #1;
         for (int k = 0; k < 2; k++) begin
            mdl(k, mr, instr[6:0], e, m);
            check($sformatf("rand c%0d dut%0d", c, k), 32'(outs(k) & ~m), 32'(e & ~m));
         end
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
